// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus bridge.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mio_state_t;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_IO_E = 4'hE;
  localparam logic [3:0] REGION_IO_F = 4'hF;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_NONE = 2'd2
  } mio_tgt_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Region decode: maps the top address nibble to a bus target.
// With MIO_BUS_ERR_EN defined only region 0 is RAM and the rest of the
// non-IO space is unmapped; otherwise all non-IO space aliases into RAM.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [3:0] region,
  output mio_tgt_t   tgt
);

  // Combinational region-to-target lookup
  always_comb begin
    tgt = TGT_RAM;
    unique case (region)
      REGION_IO_E, REGION_IO_F: tgt = TGT_IO;
`ifdef MIO_BUS_ERR_EN
      REGION_RAM:               tgt = TGT_RAM;
      default:                  tgt = TGT_NONE;
`else
      default:                  tgt = TGT_RAM;
`endif
    endcase
  end

endmodule

// File: rtl/mio_bus_bridge.sv
// Memory/IO bus bridge between the CPU core request port and block RAM /
// peripheral registers. Optional macro MIO_BUS_ERR_EN adds a bus_err output
// and reports accesses outside RAM region 0 and the IO window as errors.
//
// state  | meaning
// IDLE   | waiting for cpu_req; accepts and latches the request
// ACCESS | target strobed; cnt counts down remaining access cycles
// DONE   | mio_ready pulse, read data valid on cpu_rdata
module mio_bus_bridge
  import mio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int IO_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
`ifdef MIO_BUS_ERR_EN
  output logic              bus_err,
`endif
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_en,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata
);

  localparam logic [3:0] RAM_CNT_INIT = 4'(RAM_LAT - 1);

  mio_state_t state;
  mio_tgt_t   tgt_dec;
  mio_tgt_t   tgt_q;
  logic       we_q;
  logic [3:0] cnt;

  // Byte-lane and aliased upper address bits are don't-care for word targets.
  logic unused_addr;
  assign unused_addr = ^cpu_addr;

  mio_addr_decode u_decode (
    .region (cpu_addr[31:28]),
    .tgt    (tgt_dec)
  );

  // Request sequencing; strobes, address/data and completion are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tgt_q     <= TGT_RAM;
      we_q      <= 1'b0;
      cnt       <= 4'd0;
      cpu_rdata <= 32'h0;
      mio_ready <= 1'b0;
`ifdef MIO_BUS_ERR_EN
      bus_err   <= 1'b0;
`endif
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      io_en     <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= 32'h0;
    end else begin
      mio_ready <= 1'b0;
`ifdef MIO_BUS_ERR_EN
      bus_err   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            state <= ACCESS;
            tgt_q <= tgt_dec;
            we_q  <= cpu_we;
            cnt   <= 4'd0;
            unique case (tgt_dec)
              TGT_RAM: begin
                ram_en    <= 1'b1;
                ram_we    <= cpu_we;
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= cpu_wdata;
                cnt       <= RAM_CNT_INIT;
              end
              TGT_IO: begin
                io_en    <= 1'b1;
                io_we    <= cpu_we;
                io_addr  <= cpu_addr[IO_AW+1:2];
                io_wdata <= cpu_wdata;
              end
              default: ;
            endcase
          end
        end
        ACCESS: begin
          // Write strobe is a single pulse in the first access cycle.
          ram_we <= 1'b0;
          io_we  <= 1'b0;
          if (cnt == 4'd0) begin
            ram_en    <= 1'b0;
            io_en     <= 1'b0;
            mio_ready <= 1'b1;
            state     <= DONE;
            if (!we_q) begin
              unique case (tgt_q)
                TGT_RAM: cpu_rdata <= ram_rdata;
                TGT_IO:  cpu_rdata <= io_rdata;
                default: cpu_rdata <= 32'h0;
              endcase
            end
`ifdef MIO_BUS_ERR_EN
            if (tgt_q == TGT_NONE) bus_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Self-checking bench for mio_bus_bridge: transaction-level model predicting
// per-cycle outputs, plus literal expectations for the directed scenarios.
module tb_mio_bus_bridge;

  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam int IO_AW   = 4;
  localparam int MAXC    = 1024;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              mio_ready;
`ifdef MIO_BUS_ERR_EN
  logic              bus_err;
`endif
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              io_en;
  logic              io_we;
  logic [IO_AW-1:0]  io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic [31:0]       io_val;

  mio_bus_bridge #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .IO_AW(IO_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .mio_ready (mio_ready),
`ifdef MIO_BUS_ERR_EN
    .bus_err   (bus_err),
`endif
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_en     (io_en),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side RAM and peripheral
  logic [31:0] mem_b [0:(1<<RAM_AW)-1];
  assign ram_rdata = mem_b[ram_addr];
  assign io_rdata  = io_val;
  always @(posedge clk) if (ram_we) mem_b[ram_addr] <= ram_wdata;

  // Model state: expected outputs per cycle index
  bit [31:0] mem_m  [0:(1<<RAM_AW)-1];
  bit        e_ram_en [0:MAXC-1];
  bit        e_ram_we [0:MAXC-1];
  bit        e_io_en  [0:MAXC-1];
  bit        e_io_we  [0:MAXC-1];
  bit        e_ready  [0:MAXC-1];
  bit        e_err    [0:MAXC-1];
  bit        e_rst    [0:MAXC-1];
  bit [31:0] e_addr   [0:MAXC-1];
  bit [31:0] e_wd     [0:MAXC-1];
  bit [31:0] e_rdata  [0:MAXC-1];

  int cyc = 0;
  int free_at = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int mon_ram_en = 0, mon_ram_we = 0, mon_io_en = 0, mon_io_we = 0, mon_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one access at a time, L access cycles,
  // ready in the cycle after the last access, one idle cycle before the next.
  always @(posedge clk) begin
    int k;
    int len;
    int idx;
    bit is_io;
    bit is_none;
    bit [31:0] a;
    bit [31:0] val;
    cyc++;
    k = cyc;
    if (reset) begin
      for (int c = k; c < MAXC; c++) begin
        e_ram_en[c] = 0; e_ram_we[c] = 0; e_io_en[c] = 0; e_io_we[c] = 0;
        e_ready[c] = 0; e_err[c] = 0; e_rdata[c] = 32'h0;
      end
      if (k < MAXC) e_rst[k] = 1;
      free_at = k + 1;
    end else if (cpu_req === 1'b1 && k >= free_at) begin
      a = cpu_addr;
      is_io = (a / 32'h1000_0000) >= 14;
`ifdef MIO_BUS_ERR_EN
      is_none = !is_io && ((a / 32'h1000_0000) != 0);
`else
      is_none = 0;
`endif
      len = (is_io || is_none) ? 1 : RAM_LAT;
      idx = int'((a % (32'd1 << (RAM_AW + 2))) / 4);
      for (int c = k; c < k + len && c < MAXC; c++) begin
        if (!is_none) begin
          if (is_io) begin
            e_io_en[c] = 1;
            e_addr[c]  = (a / 4) % (32'd1 << IO_AW);
          end else begin
            e_ram_en[c] = 1;
            e_addr[c]   = idx;
          end
          e_wd[c] = cpu_wdata;
        end
      end
      if (cpu_we && !is_none && k < MAXC) begin
        if (is_io) e_io_we[k] = 1;
        else e_ram_we[k] = 1;
      end
      if (k + len < MAXC) begin
        e_ready[k+len] = 1;
        e_err[k+len]   = is_none;
      end
      if (!cpu_we) begin
        val = is_none ? 32'h0 : (is_io ? io_val : mem_m[idx]);
        for (int c = k + len; c < MAXC; c++) e_rdata[c] = val;
      end else if (!is_io && !is_none) begin
        mem_m[idx] = cpu_wdata;
      end
      free_at = k + len + 2;
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      chk("ram_en",    ram_en,    e_ram_en[cyc]);
      chk("ram_we",    ram_we,    e_ram_we[cyc]);
      chk("io_en",     io_en,     e_io_en[cyc]);
      chk("io_we",     io_we,     e_io_we[cyc]);
      chk("mio_ready", mio_ready, e_ready[cyc]);
      chk("cpu_rdata", cpu_rdata, e_rdata[cyc]);
`ifdef MIO_BUS_ERR_EN
      chk("bus_err",   bus_err,   e_err[cyc]);
`endif
      if (e_ram_en[cyc]) begin
        chk("ram_addr",  32'(ram_addr), e_addr[cyc]);
        chk("ram_wdata", ram_wdata,     e_wd[cyc]);
      end
      if (e_io_en[cyc]) begin
        chk("io_addr",  32'(io_addr), e_addr[cyc]);
        chk("io_wdata", io_wdata,     e_wd[cyc]);
      end
      if (e_rst[cyc]) begin
        chk("rst_ram_addr",  32'(ram_addr), 32'h0);
        chk("rst_io_addr",   32'(io_addr),  32'h0);
        chk("rst_ram_wdata", ram_wdata,     32'h0);
        chk("rst_io_wdata",  io_wdata,      32'h0);
      end
      mon_ram_en += int'(ram_en === 1'b1);
      mon_ram_we += int'(ram_we === 1'b1);
      mon_io_en  += int'(io_en === 1'b1);
      mon_io_we  += int'(io_we === 1'b1);
      mon_ready  += int'(mio_ready === 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int c0);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    c0 = cyc;
  endtask

  task automatic wait_ready(input string nm, output int rc);
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mio_ready === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    #1;
    if (rc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: mio_ready not seen within 40 cycles", nm);
    end
  endtask

  initial begin
    int c0, r1, r2;
    int s_ram_en, s_ram_we, s_io_en, s_io_we, s_ready;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; io_val = 32'h0;
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      mem_b[i] = 32'h0;
      mem_m[i] = 32'h0;
    end
    mem_b[4] = 32'h1234_5678;
    mem_m[4] = 32'h1234_5678;
    idle(3);
    reset = 1'b0;
    idle(1);

    // RAM read: 2 access cycles, ready 3 cycles after accept
    s_ram_en = mon_ram_en;
    issue(1'b0, 32'h0000_0010, 32'h0, c0);
    wait_ready("t1_ready", r1);
    chk("t1_latency", 32'(r1 - c0), 32'd3);
    chk("t1_rdata", cpu_rdata, 32'h1234_5678);
    cpu_req = 1'b0;
    idle(2);
    chk("t1_ram_en_cycles", 32'(mon_ram_en - s_ram_en), 32'd2);

    // IO write, cpu_req dropped during the access
    s_ram_en = mon_ram_en; s_io_we = mon_io_we; s_io_en = mon_io_en;
    issue(1'b1, 32'hE000_0004, 32'hA5A5_0001, c0);
    idle(1);
    cpu_req = 1'b0;
    wait_ready("t2_ready", r1);
    chk("t2_latency", 32'(r1 - c0), 32'd2);
    idle(2);
    chk("t2_io_we_cycles", 32'(mon_io_we - s_io_we), 32'd1);
    chk("t2_io_en_cycles", 32'(mon_io_en - s_io_en), 32'd1);
    chk("t2_ram_en_cycles", 32'(mon_ram_en - s_ram_en), 32'd0);

    // IO read
    io_val = 32'h0000_00FF;
    issue(1'b0, 32'hF000_0000, 32'h0, c0);
    wait_ready("t3_ready", r1);
    chk("t3_latency", 32'(r1 - c0), 32'd2);
    chk("t3_rdata", cpu_rdata, 32'h0000_00FF);
    cpu_req = 1'b0;
    idle(2);

    // Back-to-back RAM write then read, wdata changed mid-access
    s_ram_we = mon_ram_we; s_ready = mon_ready;
    issue(1'b1, 32'h0000_0100, 32'hCAFE_0001, c0);
    idle(1);
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_we    = 1'b0;
    wait_ready("t4_ready1", r1);
    chk("t4_latency", 32'(r1 - c0), 32'd3);
    chk("t4_rdata_kept_by_write", cpu_rdata, 32'h0000_00FF);
    wait_ready("t4_ready2", r2);
    cpu_req = 1'b0;
    // DONE, one idle cycle, two access cycles, then the second DONE
    chk("t4_ready_gap", 32'(r2 - r1), 32'd4);
    chk("t4_rdata", cpu_rdata, 32'hCAFE_0001);
    idle(2);
    chk("t4_ram_we_cycles", 32'(mon_ram_we - s_ram_we), 32'd1);
    chk("t4_ready_pulses", 32'(mon_ready - s_ready), 32'd2);

    // Reset in the second access cycle of a RAM read
    s_ready = mon_ready;
    issue(1'b0, 32'h0000_0010, 32'h0, c0);
    idle(2);
    reset   = 1'b1;
    cpu_req = 1'b0;
    idle(1);
    chk("t5_rst_ready", 32'(mio_ready), 32'd0);
    chk("t5_rst_ram_en", 32'(ram_en), 32'd0);
    chk("t5_rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    idle(3);
    chk("t5_no_ready", 32'(mon_ready - s_ready), 32'd0);
    issue(1'b0, 32'h0000_0010, 32'h0, c0);
    wait_ready("t5_fresh_ready", r1);
    chk("t5_fresh_latency", 32'(r1 - c0), 32'd3);
    chk("t5_fresh_rdata", cpu_rdata, 32'h1234_5678);
    cpu_req = 1'b0;
    idle(2);

    // IO read at the top of the register window
    io_val = 32'h5A5A_0000;
    issue(1'b0, 32'hF000_003C, 32'h0, c0);
    wait_ready("t6_ready", r1);
    chk("t6_rdata", cpu_rdata, 32'h5A5A_0000);
    cpu_req = 1'b0;
    idle(2);

`ifdef MIO_BUS_ERR_EN
    // Unmapped region: no strobes, error with ready, zero data
    s_ram_en = mon_ram_en; s_io_en = mon_io_en;
    issue(1'b0, 32'h4000_0000, 32'h0, c0);
    wait_ready("t7_ready", r1);
    chk("t7_latency", 32'(r1 - c0), 32'd2);
    chk("t7_bus_err", 32'(bus_err), 32'd1);
    chk("t7_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    idle(2);
    chk("t7_no_strobes", 32'(mon_ram_en - s_ram_en + mon_io_en - s_io_en), 32'd0);
`else
    // Upper address bits alias into RAM word 4
    issue(1'b0, 32'h4000_1010, 32'h0, c0);
    wait_ready("t7_ready", r1);
    chk("t7_latency", 32'(r1 - c0), 32'd3);
    chk("t7_alias_rdata", cpu_rdata, 32'h1234_5678);
    cpu_req = 1'b0;
    idle(2);
`endif

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_bridge.md
Name: mio_bus_bridge

Overview:
- Memory/IO bus bridge directly downstream of the CPU core.
- Consumes the core's memory request outputs: CPU_MIO request, mem_w, Addr_out and Data_out.
- Decodes the address to block RAM or the peripheral window, sequences the access with wait states, and returns read data plus a one-cycle MIO_ready completion pulse.
- The core stalls on MIO_ready.

Parameters:
- RAM_AW, 10, RAM word-address width (depth 2^RAM_AW words).
- RAM_LAT, 2, RAM access cycles, legal range 1..15.
- IO_AW, 4, peripheral register word-address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request from core (CPU_MIO), held until mio_ready
- cpu_we  in  1  1=write, 0=read (mem_w)
- cpu_addr  in  32  byte address (Addr_out)
- cpu_wdata  in  32  write data (Data_out)
- cpu_rdata  out  32  read data, valid while mio_ready=1, held until next read completes
- mio_ready  out  1  one-cycle completion pulse
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write strobe
- ram_addr  out  RAM_AW  RAM word address = addr[RAM_AW+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid at end of last ACCESS cycle
- io_en  out  1  peripheral strobe
- io_we  out  1  peripheral write strobe
- io_addr  out  IO_AW  peripheral word address = addr[IO_AW+1:2]
- io_wdata  out  32  peripheral write data
- io_rdata  in  32  peripheral read data, same-cycle

Behaviour:
- Reset value of every output is 0. Reset forces IDLE, clears the latched request and wait counter, and abandons any access in progress; no mio_ready is issued for it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - cpu_req=1 latches addr, we and wdata, decodes the region, and moves to ACCESS.
  - cnt is loaded with RAM_LAT-1 for RAM, or 0 for IO.
- Decode on addr[31:28]:
  - 4'hE or 4'hF: IO window.
  - Anything else: RAM; upper bits are ignored and the address aliases modulo 2^(RAM_AW+2).
  - addr[1:0] is ignored; all accesses are word accesses.
- ACCESS:
  - ram_en/io_en is asserted for every ACCESS cycle of the selected target.
  - ram_we/io_we is asserted only in the first ACCESS cycle, giving a single write pulse.
  - Addr and wdata outputs are driven from the latched registers only, never from live cpu_* inputs.
  - cnt decrements each cycle. When cnt=0, read data from the selected target is captured into cpu_rdata (reads only) and the state moves to DONE.
- DONE: mio_ready=1 for exactly one cycle, then IDLE.
- Latency from the accept cycle to the mio_ready cycle: RAM = RAM_LAT+1, IO = 2.
- Back-to-back: a request still high in the IDLE cycle after DONE starts a new access. The minimum gap between mio_ready pulses is 1 idle cycle.
- cpu_req dropping mid-access is ignored; the access completes and mio_ready still pulses.
- cpu_rdata is not updated by writes.
- At most one strobe family (ram_* or io_*) is active in any cycle.

Optional Feature:
- Macro: MIO_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit, reset 0).
  - Only addr[31:28]=4'h0 maps to RAM; 4'h1..4'hD are unmapped.
  - An unmapped access asserts no strobes, takes 1 ACCESS cycle, returns cpu_rdata=32'h0, and raises bus_err together with mio_ready for that one cycle.
- Undefined: no bus_err port, and aliasing works as described above.

Decomposition:
- Shared package mio_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - Region constants REGION_RAM=4'h0, REGION_IO_E=4'hE, REGION_IO_F=4'hF.
  - Target-select encoding (TGT_RAM, TGT_IO, TGT_NONE).
- One natural sub-module: mio_addr_decode, purely combinational, mapping addr[31:28] to a target select. Sequencing stays in mio_bus_bridge.

Test Plan:
- Read RAM: RAM_LAT=2, read addr 32'h0000_0010 with RAM model returning 32'h1234_5678 -> ram_addr=4, ram_en high 2 cycles, mio_ready pulses 3 cycles after accept, cpu_rdata=32'h1234_5678.
- Write IO then read IO:
  - Write 32'hE000_0004 data 32'hA5A5_0001 -> io_we pulses exactly 1 cycle with io_addr=1, mio_ready 2 cycles after accept, ram_* idle throughout.
  - Read 32'hF000_0000 with io_rdata=32'h0000_00FF -> cpu_rdata=32'h0000_00FF.
- Back-to-back with mid-access change: hold cpu_req high for a RAM write then a RAM read, changing cpu_wdata mid-access -> ram_wdata stays at the latched value, ram_we single pulse, two mio_ready pulses separated by exactly 1 idle cycle.
- Reset mid-access: assert reset in the 2nd ACCESS cycle of a RAM read -> next cycle IDLE, all outputs 0, no mio_ready pulse; a fresh request afterwards completes normally.
- Error path, with MIO_BUS_ERR_EN: read 32'h4000_0000 -> no ram_en/io_en, mio_ready and bus_err high together 2 cycles after accept, cpu_rdata=0. Without the macro the same address aliases to ram_addr=0.
